// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared types for the sort sequencer: the three-state FSM
//                enumeration and a helper giving the compare-phase length.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of compare cycles a full bubble sort of `depth` words takes.
    function automatic int sort_cycles(input int depth);
        return depth * (depth - 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slt.sv
`default_nettype none
// ============================================================================
//  Module      : slt
//  Description : Structural signed (two's complement) less-than comparator.
//                Both operands are sign-extended by one bit and a - b is
//                formed as a + ~b + 1 with a ripple carry chain; the sign bit
//                of that N+1 bit difference cannot overflow, so it is the
//                answer directly.
//  Ports       : a_i  [N-1:0]  left operand
//                b_i  [N-1:0]  right operand
//                lt_o          1 when signed(a_i) < signed(b_i)
//  Revision    : 1.0  initial release
// ============================================================================
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         lt_o
);

    logic [N:0] w_a_ext;
    logic [N:0] w_b_inv;
    logic [N:0] w_carry;

    assign w_a_ext    = {a_i[N-1], a_i};
    assign w_b_inv    = ~{b_i[N-1], b_i};
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_carry
            assign w_carry[gi+1] = (w_a_ext[gi] & w_b_inv[gi]) |
                                   (w_carry[gi] & (w_a_ext[gi] ^ w_b_inv[gi]));
        end
    endgenerate

    // Only the sign bit of the difference is needed.
    assign lt_o = w_a_ext[N] ^ w_b_inv[N] ^ w_carry[N];

endmodule
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sort_sequencer
//  Description : Loads a batch of DEPTH signed words, bubble-sorts them in
//                place with a single shared comparator (fixed DEPTH*(DEPTH-1)/2
//                compare cycles), then streams them out in ascending order.
//  Ports       : clk, rst                 clock, asynchronous active-high reset
//                in_valid/in_ready/in_data   input word handshake (LOAD only)
//                out_valid/out_ready/out_data sorted word handshake (DRAIN only)
//                busy                     high while sorting
//  Revision    : 1.0  initial release
// ============================================================================
module sort_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    import sort_pkg::*;

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [CW-1:0]  LAST_IDX  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  LAST_PASS = CW'(DEPTH - 2);

    state_t        state_q;
    logic [CW-1:0] wr_idx_q;
    logic [CW-1:0] rd_idx_q;
    logic [CW-1:0] j_q;
    logic [CW-1:0] p_q;
    logic [N-1:0]  mem_q [DEPTH];
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [N-1:0]  w_lo;
    logic [N-1:0]  w_hi;
    logic          w_lt;
    logic          w_pass_end;

    // The pair under comparison: slot j and slot j+1.
    assign w_lo = mem_q[j_q[AW-1:0]];
    assign w_hi = mem_q[AW'(j_q + CW'(1))];

    // Swap when the upper slot is strictly smaller; equal words stay put.
    slt #(.N(N)) u_slt (
        .a_i  (w_hi),
        .b_i  (w_lo),
        .lt_o (w_lt)
    );

    // Pass p compares j = 0 .. DEPTH-2-p.
    assign w_pass_end = (j_q == (LAST_PASS - p_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        mem_q[wr_idx_q[AW-1:0]] <= in_data;
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_q   <= '0;
                            j_q        <= '0;
                            p_q        <= '0;
                            state_q    <= SORT;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + CW'(1);
                        end
                    end
                end

                SORT: begin
                    if (w_lt) begin
                        mem_q[j_q[AW-1:0]]       <= w_hi;
                        mem_q[AW'(j_q + CW'(1))] <= w_lo;
                    end
                    if (w_pass_end) begin
                        j_q <= '0;
                        if (p_q == LAST_PASS) begin
                            p_q         <= '0;
                            rd_idx_q    <= '0;
                            state_q     <= DRAIN;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            p_q <= p_q + CW'(1);
                        end
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end

                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q    <= '0;
                            state_q     <= LOAD;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            rd_idx_q <= rd_idx_q + CW'(1);
                        end
                    end
                end

                default: begin
                    state_q     <= LOAD;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // rd_idx only advances in DRAIN, so this holds steady while stalled.
    assign out_data  = mem_q[rd_idx_q[AW-1:0]];

endmodule
`default_nettype wire
